// File: rtl/pll_sup_pkg.sv
// PLL lock supervisor: shared state encoding and
// elaboration-time parameter helpers.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAULT
  } state_t;

  function automatic int cnt_w(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

  function automatic bit params_ok(
    input int nch,
    input int rst,
    input int tmo,
    input int stab,
    input int stg,
    input int mr,
    input int sync
  );
    return nch >= 1 && nch <= 16 &&
           rst >= 1 && tmo >= 1 &&
           stab >= 1 && stg >= 1 &&
           mr >= 1 && mr <= 15 &&
           sync >= 2;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_ff.sv
// Multi-flop synchroniser for the asynchronous
// PLL LOCK input, async reset to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: PLL reset/power-down,
// lock qualification, retry and staggered releases.
module pll_lock_supervisor #(
  parameter int NUM_CH       = 4,
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_TMO_CYC = 500000,
  parameter int STABLE_CYC   = 1024,
  parameter int STAGGER_CYC  = 64,
  parameter int MAX_RETRY    = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              soft_restart,
  output logic              pll_reset,
  output logic              pll_pwd,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              ready,
  output logic              fault,
  output logic [3:0]        retry_cnt,
  output logic [15:0]       loss_cnt
);

  import pll_sup_pkg::*;

  localparam int CW = cnt_w(PLL_RST_CYC,
    LOCK_TMO_CYC, STABLE_CYC, STAGGER_CYC);
  localparam int IW = (NUM_CH > 1) ?
    $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0] RST_END =
    CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] TMO_END =
    CW'(LOCK_TMO_CYC - 1);
  localparam logic [CW-1:0] STB_END =
    CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] STG_END =
    CW'(STAGGER_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX =
    IW'(NUM_CH - 2);
  localparam logic [3:0] RTY_LAST =
    4'(MAX_RETRY - 1);

  if (!params_ok(NUM_CH, PLL_RST_CYC,
      LOCK_TMO_CYC, STABLE_CYC, STAGGER_CYC,
      MAX_RETRY, SYNC_STAGES)) begin : g_bad
    $error("pll_lock_supervisor: bad params");
  end

  logic          lock_s;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          lost;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pll_lock),
    .q    (lock_s)
  );

  assign lost = !lock_s &&
    (state == RELEASE || state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      idx       <= '0;
      pll_reset <= 1'b1;
      pll_pwd   <= 1'b0;
      ch_rst_n  <= '0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else if (soft_restart) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      idx       <= '0;
      pll_reset <= 1'b1;
      pll_pwd   <= 1'b0;
      ch_rst_n  <= '0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
    end else if (lost) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      idx       <= '0;
      pll_reset <= 1'b1;
      ch_rst_n  <= '0;
      ready     <= 1'b0;
      if (loss_cnt != 16'hFFFF)
        loss_cnt <= loss_cnt + 16'd1;
    end else begin
      cnt <= cnt + 1'b1;
      unique case (state)
        RESET_PLL: begin
          if (cnt == RST_END) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TMO_END) begin
            cnt       <= '0;
            pll_reset <= 1'b1;
            retry_cnt <= retry_cnt + 4'd1;
            if (retry_cnt == RTY_LAST) begin
              state   <= FAULT;
              fault   <= 1'b1;
              pll_pwd <= 1'b1;
            end else begin
              state <= RESET_PLL;
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STB_END) begin
            cnt      <= '0;
            idx      <= '0;
            ch_rst_n <= NUM_CH'(1);
            if (NUM_CH == 1) begin
              state     <= RUN;
              ready     <= 1'b1;
              retry_cnt <= '0;
            end else begin
              state <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (cnt == STG_END) begin
            cnt      <= '0;
            idx      <= idx + 1'b1;
            ch_rst_n <= (ch_rst_n << 1) |
                        NUM_CH'(1);
            if (idx == LAST_IDX) begin
              state     <= RUN;
              ready     <= 1'b1;
              retry_cnt <= '0;
            end
          end
        end
        RUN: begin
          cnt <= cnt;
        end
        FAULT: begin
          cnt <= cnt;
        end
        default: begin
          state <= RESET_PLL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: vector table,
// corner sequences and randomized model run.
module tb_pll_lock_supervisor;

  localparam int NCH = 4;
  localparam int PRC = 4;
  localparam int TMO = 50;
  localparam int STB = 8;
  localparam int STG = 3;
  localparam int MR  = 3;
  localparam int SYN = 2;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STB  = 2;
  localparam int P_REL  = 3;
  localparam int P_RUN  = 4;
  localparam int P_FLT  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll_lock = 1'b0;
  logic        soft_restart = 1'b0;
  logic        pll_reset;
  logic        pll_pwd;
  logic [3:0]  ch_rst_n;
  logic        ready;
  logic        fault;
  logic [3:0]  retry_cnt;
  logic [15:0] loss_cnt;

  pll_lock_supervisor #(
    .NUM_CH      (NCH),
    .PLL_RST_CYC (PRC),
    .LOCK_TMO_CYC(TMO),
    .STABLE_CYC  (STB),
    .STAGGER_CYC (STG),
    .MAX_RETRY   (MR),
    .SYNC_STAGES (SYN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .soft_restart(soft_restart),
    .pll_reset   (pll_reset),
    .pll_pwd     (pll_pwd),
    .ch_rst_n    (ch_rst_n),
    .ready       (ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .loss_cnt    (loss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic check(input string name,
    input logic [31:0] got,
    input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
      name, got, exp);
  endtask

  function automatic logic [27:0] pack(
    input logic pr, input logic pw,
    input logic [3:0] ch, input logic rd,
    input logic fl, input logic [3:0] rt,
    input logic [15:0] ls);
    return {pr, pw, ch, rd, fl, rt, ls};
  endfunction

  function automatic logic [27:0] act();
    return pack(pll_reset, pll_pwd, ch_rst_n,
      ready, fault, retry_cnt, loss_cnt);
  endfunction

  // Reference model: phase plus absolute entry time,
  // channel release tracked as a count of channels.
  int m_ph, m_ke, m_k, m_rel, m_retry, m_loss;
  bit q[$];

  task automatic m_reset();
    m_ph = P_RST; m_ke = 0; m_k = 0;
    m_rel = 0; m_retry = 0; m_loss = 0;
    q = {};
    repeat (SYN) q.push_back(1'b0);
  endtask

  task automatic m_step(input bit lk, input bit sr);
    bit ls;
    int n;
    m_k++;
    ls = q[0];
    void'(q.pop_front());
    q.push_back(lk);
    n = m_k - m_ke;
    if (sr) begin
      m_ph = P_RST; m_ke = m_k;
      m_rel = 0; m_retry = 0;
    end else if ((m_ph == P_REL ||
                  m_ph == P_RUN) && !ls) begin
      m_ph = P_RST; m_ke = m_k; m_rel = 0;
      if (m_loss < 65535) m_loss++;
    end else begin
      case (m_ph)
        P_RST:
          if (n == PRC) begin
            m_ph = P_WAIT; m_ke = m_k;
          end
        P_WAIT:
          if (ls) begin
            m_ph = P_STB; m_ke = m_k;
          end else if (n == TMO) begin
            m_retry++;
            m_ph = (m_retry == MR) ? P_FLT : P_RST;
            m_ke = m_k;
          end
        P_STB:
          if (!ls) begin
            m_ph = P_WAIT; m_ke = m_k;
          end else if (n == STB) begin
            m_rel = 1; m_ke = m_k;
            m_ph = (m_rel == NCH) ? P_RUN : P_REL;
            if (m_ph == P_RUN) m_retry = 0;
          end
        P_REL:
          if (n == STG) begin
            m_rel++; m_ke = m_k;
            if (m_rel == NCH) begin
              m_ph = P_RUN; m_retry = 0;
            end
          end
        default: ;
      endcase
    end
  endtask

  function automatic logic [27:0] m_exp();
    logic [3:0] mk;
    mk = 4'((1 << m_rel) - 1);
    return pack(m_ph == P_RST || m_ph == P_FLT,
      m_ph == P_FLT, mk, m_ph == P_RUN,
      m_ph == P_FLT, 4'(m_retry), 16'(m_loss));
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step(pll_lock, soft_restart);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pll_lock = 1'b0;
    soft_restart = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  typedef struct {
    bit          lk;
    int          n;
    bit          prst;
    logic [3:0]  ch;
    bit          rdy;
    logic [15:0] loss;
  } vec_t;

  function automatic vec_t mv(input bit lk,
    input int n, input bit prst,
    input logic [3:0] ch, input bit rdy,
    input logic [15:0] loss);
    vec_t v;
    v.lk = lk; v.n = n; v.prst = prst;
    v.ch = ch; v.rdy = rdy; v.loss = loss;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    int n;
    int runs[$];
    int first_fault;
    int len;
    logic cur;
    int left;

    tbl[0]  = mv(0, 3,  1, 4'h0, 0, 16'd0);
    tbl[1]  = mv(0, 1,  0, 4'h0, 0, 16'd0);
    tbl[2]  = mv(0, 20, 0, 4'h0, 0, 16'd0);
    tbl[3]  = mv(1, 10, 0, 4'h0, 0, 16'd0);
    tbl[4]  = mv(1, 1,  0, 4'h1, 0, 16'd0);
    tbl[5]  = mv(1, 2,  0, 4'h1, 0, 16'd0);
    tbl[6]  = mv(1, 1,  0, 4'h3, 0, 16'd0);
    tbl[7]  = mv(1, 3,  0, 4'h7, 0, 16'd0);
    tbl[8]  = mv(1, 2,  0, 4'h7, 0, 16'd0);
    tbl[9]  = mv(1, 1,  0, 4'hF, 1, 16'd0);
    tbl[10] = mv(1, 5,  0, 4'hF, 1, 16'd0);
    tbl[11] = mv(0, 2,  0, 4'hF, 1, 16'd0);
    tbl[12] = mv(0, 1,  1, 4'h0, 0, 16'd1);
    tbl[13] = mv(0, 4,  0, 4'h0, 0, 16'd1);
    tbl[14] = mv(1, 11, 0, 4'h1, 0, 16'd1);
    tbl[15] = mv(1, 9,  0, 4'hF, 1, 16'd1);

    do_reset();
    check("reset", act(),
      pack(1, 0, 4'h0, 0, 0, 4'h0, 16'h0));

    for (int i = 0; i < 16; i++) begin
      pll_lock = tbl[i].lk;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d", i), act(),
        pack(tbl[i].prst, 0, tbl[i].ch,
          tbl[i].rdy, 0, 4'h0, tbl[i].loss));
    end

    do_reset();
    runs = {};
    first_fault = -1;
    cur = pll_reset;
    len = 1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (fault && first_fault < 0) begin
        first_fault = k;
        runs.push_back(len);
      end else if (first_fault < 0) begin
        if (pll_reset == cur) len++;
        else begin
          runs.push_back(len);
          cur = pll_reset;
          len = 1;
        end
      end
    end
    check("tmo_runs", runs.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("tmo_run%0d", i),
        (i < runs.size()) ? runs[i] : -1,
        (i % 2 == 0) ? PRC : TMO);
    check("tmo_fault_at", first_fault, 162);
    check("tmo_fault", act(),
      pack(1, 1, 4'h0, 0, 1, 4'd3, 16'h0));

    soft_restart = 1'b1;
    tick();
    soft_restart = 1'b0;
    pll_lock = 1'b1;
    check("sr_clear", act(),
      pack(1, 0, 4'h0, 0, 0, 4'h0, 16'h0));
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    check("sr_ready_lat", n, 22);
    check("sr_ready", act(),
      pack(0, 0, 4'hF, 1, 0, 4'h0, 16'h0));

    do_reset();
    repeat (10) tick();
    pll_lock = 1'b1;
    repeat (7) tick();
    pll_lock = 1'b0;
    repeat (2) tick();
    pll_lock = 1'b1;
    repeat (2) tick();
    check("glitch_hold", ch_rst_n, 4'h0);
    repeat (8) tick();
    check("glitch_late", act(),
      pack(0, 0, 4'h0, 0, 0, 4'h0, 16'h0));
    tick();
    check("glitch_rel", ch_rst_n, 4'h1);

    do_reset();
    pll_lock = 1'b1;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    check("c_ready", ready, 1);
    pll_lock = 1'b0;
    n = 0;
    while (loss_cnt != 16'd1 && n < 20) begin
      tick();
      n++;
    end
    check("c_loss", act(),
      pack(1, 0, 4'h0, 0, 0, 4'h0, 16'd1));
    pll_lock = 1'b1;
    n = 0;
    while (ch_rst_n != 4'h3 && n < 100) begin
      tick();
      n++;
    end
    check("c_mid_rel", ch_rst_n, 4'h3);
    #2 rst_n = 1'b0;
    #1;
    check("c_async_rst", act(),
      pack(1, 0, 4'h0, 0, 0, 4'h0, 16'h0));

    do_reset();
    left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (left == 0) begin
        pll_lock = ~pll_lock;
        left = ($urandom_range(0, 7) == 0) ?
          200 : int'($urandom_range(1, 70));
      end
      left--;
      soft_restart =
        ($urandom_range(0, 299) == 0);
      tick();
      check("model", act(), m_exp());
    end

    $display("%0d/%0d checks passed",
      passed, total);
    $finish;
  end

endmodule
